rs_dec_single_err_locator: RTL and testbench

- Stage directly downstream of the RS(32,28) syndrome calculator. Consumes the four syndromes S0..S3 once per frame.
- Classifies the frame as no-error, single correctable error, or uncorrectable.
- For a single error, finds the byte position with a sequential alpha-stepping search (one GF(256) multiply per clock) and reports position and magnitude to the correction/output stage.
- GF(256) uses the codebase field: poly 0x11D, alpha = 0x02. Arithmetic comes from the existing gf256_mult and gf256_sum cells.

---
 rtl/rs_dec_single_err_locator.sv | 183 ++++++++++++++++++
 tb/tb_rs_dec_single_err_locator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dec_single_err_locator.sv
// RS(32,28) single-error locator: classifies the four syndromes and, for a
// single error, walks alpha powers one GF(256) multiply per clock to find it.

module gf256_mult (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] acc;
  logic [7:0] sh;

  // Shift-and-add over GF(2^8) with reduction polynomial 0x11D.
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    p = acc;
  end
endmodule

module gf256_sum (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a ^ b;
endmodule

module rs_dec_single_err_locator #(
  parameter int N_SYMB = 32
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_start,
  input  logic [7:0] i_s0,
  input  logic [7:0] i_s1,
  input  logic [7:0] i_s2,
  input  logic [7:0] i_s3,
  output logic       o_busy,
  output logic       o_done,
  output logic [1:0] o_status,
  output logic [4:0] o_err_pos,
  output logic [7:0] o_err_val
);

  typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_t;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  state_t     state_reg;
  logic [7:0] s0_reg, s1_reg, s2_reg, s3_reg;
  logic [7:0] c_reg;
  logic [5:0] p_reg;
  logic       busy_reg, done_reg;
  logic [1:0] status_reg;
  logic [4:0] pos_reg;
  logic [7:0] val_reg;

  // Consistency products: index 0/1 form check A, index 2/3 form check B.
  logic [7:0] mul_a [4];
  logic [7:0] mul_b [4];
  logic [7:0] mul_p [4];

  assign mul_a[0] = s1_reg;  assign mul_b[0] = s1_reg;
  assign mul_a[1] = s0_reg;  assign mul_b[1] = s2_reg;
  assign mul_a[2] = s2_reg;  assign mul_b[2] = s2_reg;
  assign mul_a[3] = s1_reg;  assign mul_b[3] = s3_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chk_mult
      gf256_mult u_mult (
        .a (mul_a[gi]),
        .b (mul_b[gi]),
        .p (mul_p[gi])
      );
    end
  endgenerate

  logic [7:0] diff_a, diff_b;

  gf256_sum u_sum_a (.a(mul_p[0]), .b(mul_p[1]), .y(diff_a));
  gf256_sum u_sum_b (.a(mul_p[2]), .b(mul_p[3]), .y(diff_b));

  logic [7:0] c_next;
  logic [5:0] p_next;
  logic [4:0] pos_calc;
  logic       all_zero, inconsistent, hit, span_end;

  gf256_mult u_step (.a(c_reg), .b(8'h02), .p(c_next));

  assign p_next       = p_reg + 6'd1;
  // (32 - p') mod 32 reduces to the 5-bit negation of p'.
  assign pos_calc     = 5'd0 - p_next[4:0];
  assign all_zero     = (s0_reg == 8'h00) && (s1_reg == 8'h00) &&
                        (s2_reg == 8'h00) && (s3_reg == 8'h00);
  assign inconsistent = (s0_reg == 8'h00) || (diff_a != 8'h00) || (diff_b != 8'h00);
  assign hit          = (c_next == s1_reg);
  assign span_end     = (p_next == 6'(N_SYMB));

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state_reg  <= IDLE;
      s0_reg     <= 8'h00;
      s1_reg     <= 8'h00;
      s2_reg     <= 8'h00;
      s3_reg     <= 8'h00;
      c_reg      <= 8'h00;
      p_reg      <= 6'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      status_reg <= ST_CLEAN;
      pos_reg    <= 5'd0;
      val_reg    <= 8'h00;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            s0_reg    <= i_s0;
            s1_reg    <= i_s1;
            s2_reg    <= i_s2;
            s3_reg    <= i_s3;
            busy_reg  <= 1'b1;
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          if (all_zero || inconsistent) begin
            status_reg <= all_zero ? ST_CLEAN : ST_UNCORR;
            pos_reg    <= 5'd0;
            val_reg    <= 8'h00;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end else begin
            c_reg     <= s0_reg;
            p_reg     <= 6'd0;
            state_reg <= SEARCH;
          end
        end
        SEARCH: begin
          c_reg <= c_next;
          p_reg <= p_next;
          if (hit) begin
            status_reg <= ST_SINGLE;
            pos_reg    <= pos_calc;
            val_reg    <= s0_reg;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end else if (span_end) begin
            // Consistent locator that lies outside the 32-byte codeword.
            status_reg <= ST_UNCORR;
            pos_reg    <= 5'd0;
            val_reg    <= 8'h00;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_busy    = busy_reg;
  assign o_done    = done_reg;
  assign o_status  = status_reg;
  assign o_err_pos = pos_reg;
  assign o_err_val = val_reg;

endmodule

// File: tb/tb_rs_dec_single_err_locator.sv
// Directed bench for the RS(32,28) single-error locator: latency, busy window,
// classification, located position/magnitude, ignored starts and async reset.

module tb_rs_dec_single_err_locator;

  logic       i_clk = 1'b0;
  logic       i_resb;
  logic       i_start;
  logic [7:0] i_s0, i_s1, i_s2, i_s3;
  logic       o_busy, o_done;
  logic [1:0] o_status;
  logic [4:0] o_err_pos;
  logic [7:0] o_err_val;

  int vectors = 0;
  int miscompares = 0;

  rs_dec_single_err_locator #(.N_SYMB(32)) dut (
    .i_clk     (i_clk),
    .i_resb    (i_resb),
    .i_start   (i_start),
    .i_s0      (i_s0),
    .i_s1      (i_s1),
    .i_s2      (i_s2),
    .i_s3      (i_s3),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_status  (o_status),
    .o_err_pos (o_err_pos),
    .o_err_val (o_err_val)
  );

  always #5 i_clk = ~i_clk;

  // e * alpha^n by repeated multiply-by-x with reduction 0x11D.
  function automatic logic [7:0] apow(input logic [7:0] e, input int n);
    logic [7:0] v;
    v = e;
    for (int i = 0; i < n; i++)
      v = v[7] ? ({v[6:0], 1'b0} ^ 8'h1D) : {v[6:0], 1'b0};
    return v;
  endfunction

  // Starts a frame at the current negedge and follows it to o_done.
  // inject: cycle offset at which a stray start is pulsed (0 = none).
  // poke: raise i_start in the o_done cycle and leave the bench at the next
  // negedge with it still high, so the caller can start the next frame there.
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                     input logic [7:0] d, input int lat, input logic [1:0] st,
                     input logic [4:0] pos, input logic [7:0] val, input string name,
                     input int inject, input bit poke);
    int done_at;
    int busy_bad;
    int cyc;
    i_s0 = a; i_s1 = b; i_s2 = c; i_s3 = d;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    done_at = -1;
    busy_bad = 0;
    cyc = 1;
    while (cyc <= 60) begin
      if (o_done === 1'b1) begin
        done_at = cyc;
        break;
      end
      if (o_busy !== 1'b1 && busy_bad == 0) busy_bad = cyc;
      if (cyc == inject) begin
        i_start = 1'b1;
        i_s0 = 8'h01; i_s1 = 8'h02; i_s2 = 8'h05; i_s3 = 8'h00;
      end else if (cyc == inject + 1) begin
        i_start = 1'b0;
      end
      @(negedge i_clk);
      cyc++;
    end
    vectors++;
    if (done_at !== lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d, want %0d", name, done_at, lat);
    end
    vectors++;
    if (busy_bad != 0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy: low at cycle %0d, at done %b, want high until done then 0",
               name, busy_bad, o_busy);
    end
    vectors++;
    if (o_status !== st) begin
      miscompares++;
      $display("FAIL %s status: got %b, want %b", name, o_status, st);
    end
    vectors++;
    if (o_err_pos !== pos) begin
      miscompares++;
      $display("FAIL %s pos: got %0d, want %0d", name, o_err_pos, pos);
    end
    vectors++;
    if (o_err_val !== val) begin
      miscompares++;
      $display("FAIL %s val: got %02h, want %02h", name, o_err_val, val);
    end
    if (poke) begin
      i_start = 1'b1;
      i_s0 = 8'h00; i_s1 = 8'h01; i_s2 = 8'h00; i_s3 = 8'h00;
    end
    @(negedge i_clk);
    if (!poke) i_start = 1'b0;
    vectors++;
    if (o_done !== 1'b0 || o_status !== st || o_err_pos !== pos || o_err_val !== val) begin
      miscompares++;
      $display("FAIL %s hold: done=%b st=%b pos=%0d val=%02h, want done=0 st=%b pos=%0d val=%02h",
               name, o_done, o_status, o_err_pos, o_err_val, st, pos, val);
    end
    $display("frame %s: done at +%0d status %b pos %0d val %02h", name, done_at,
             o_status, o_err_pos, o_err_val);
  endtask

  task automatic check_outputs_zero(input string name);
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_status !== 2'b00 ||
        o_err_pos !== 5'd0 || o_err_val !== 8'h00) begin
      miscompares++;
      $display("FAIL %s: busy=%b done=%b st=%b pos=%0d val=%02h, want all 0",
               name, o_busy, o_done, o_status, o_err_pos, o_err_val);
    end
  endtask

  task automatic test_reset();
    i_resb = 1'b0;
    i_start = 1'b0;
    i_s0 = 8'h00; i_s1 = 8'h00; i_s2 = 8'h00; i_s3 = 8'h00;
    repeat (3) @(negedge i_clk);
    check_outputs_zero("reset");
    i_resb = 1'b1;
    @(negedge i_clk);
    check_outputs_zero("post-reset idle");
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    run(8'h00, 8'h00, 8'h00, 8'h00, 2, 2'b00, 5'd0, 8'h00, "zero", 0, 1'b0);
    run(8'h5A, 8'hB4, 8'h75, 8'hEA, 3, 2'b01, 5'd31, 8'h5A, "e5A_k31", 0, 1'b0);
  endtask

  task automatic test_sweep();
    logic [7:0] elist [2];
    logic [7:0] e;
    elist[0] = 8'h01;
    elist[1] = 8'hFF;
    for (int ei = 0; ei < 2; ei++) begin
      e = elist[ei];
      for (int k = 0; k < 32; k++) begin
        run(apow(e, 0), apow(e, 32 - k), apow(e, 2 * (32 - k)), apow(e, 3 * (32 - k)),
            2 + (32 - k), 2'b01, 5'(k), e, $sformatf("sweep_e%02h_k%0d", e, k), 0, 1'b0);
      end
    end
  endtask

  task automatic test_uncorrectable();
    run(8'h01, 8'h02, 8'h05, 8'h00, 2, 2'b10, 5'd0, 8'h00, "unc_inconsistent", 0, 1'b0);
    run(8'h00, 8'h01, 8'h00, 8'h00, 2, 2'b10, 5'd0, 8'h00, "unc_s0_zero", 0, 1'b0);
    run(8'h01, apow(8'h01, 40), apow(8'h01, 80), apow(8'h01, 120), 34, 2'b10, 5'd0,
        8'h00, "unc_out_of_span", 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run(8'hFF, apow(8'hFF, 32), apow(8'hFF, 64), apow(8'hFF, 96), 34, 2'b01, 5'd0,
        8'hFF, "stray_start_mid_search", 5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run(8'h5A, 8'hB4, 8'h75, 8'hEA, 3, 2'b01, 5'd31, 8'h5A, "b2b_first", 0, 1'b1);
    run(8'h00, 8'h00, 8'h00, 8'h00, 2, 2'b00, 5'd0, 8'h00, "b2b_second", 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    run(8'h5A, 8'hB4, 8'h75, 8'hEA, 3, 2'b01, 5'd31, 8'h5A, "pre_abort", 0, 1'b0);
    i_s0 = 8'h01; i_s1 = apow(8'h01, 32); i_s2 = apow(8'h01, 64); i_s3 = apow(8'h01, 96);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    seen_done = 0;
    for (int cyc = 1; cyc < 10; cyc++) begin
      if (o_done === 1'b1) seen_done = 1;
      @(negedge i_clk);
    end
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort busy before reset: got %b, want 1", o_busy);
    end
    i_resb = 1'b0;
    #1;
    check_outputs_zero("abort immediate clear");
    repeat (3) begin
      @(negedge i_clk);
      if (o_done === 1'b1) seen_done = 1;
    end
    i_resb = 1'b1;
    repeat (30) begin
      @(negedge i_clk);
      if (o_done === 1'b1) seen_done = 1;
    end
    vectors++;
    if (seen_done != 0) begin
      miscompares++;
      $display("FAIL abort no_done: got o_done pulse, want none");
    end
    check_outputs_zero("abort idle after release");
    $display("abort: reset mid-search checked");
    run(8'h5A, 8'hB4, 8'h75, 8'hEA, 3, 2'b01, 5'd31, 8'h5A, "post_abort", 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_uncorrectable();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
